// File: rtl/periph_bus_bridge.sv
`default_nettype none
// =============================================================================
// Module   : periph_bus_bridge
// Brief    : Single-outstanding CPU-to-peripheral bus bridge with registered
//            outputs and lowest-index response arbitration. Defining the
//            macro PERIPH_BUS_TIMEOUT_EN adds a WAIT-state timeout abort.
// Revision : 1.0 - initial release
// =============================================================================
module periph_bus_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_PERIPH     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             mem_clk,
   input  logic                             cpu_reset,
   input  logic                             cpu_valid_i,
   input  logic                             cpu_read_i,
   input  logic                             cpu_write_i,
   input  logic [ADDR_WIDTH-1:0]            cpu_addr_i,
   input  logic [DATA_WIDTH-1:0]            cpu_data_i,
   output logic                             cpu_busy_o,
   output logic                             cpu_valid_o,
   output logic [DATA_WIDTH-1:0]            cpu_data_o,
   output logic                             cpu_error_o,
   output logic                             mem_valid_o,
   output logic                             mem_read_o,
   output logic                             mem_write_o,
   output logic [ADDR_WIDTH-1:0]            mem_addr_o,
   output logic [DATA_WIDTH-1:0]            mem_data_o,
   input  logic [NUM_PERIPH-1:0]            periph_valid_i,
   input  logic [NUM_PERIPH*DATA_WIDTH-1:0] periph_data_i
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("periph_bus_bridge: TIMEOUT_CYCLES must be within 1..255");
   end

   state_t                state_q, state_d;
   logic                  busy_q, busy_d;
   logic                  cpu_valid_q, cpu_valid_d;
   logic [DATA_WIDTH-1:0] cpu_data_q, cpu_data_d;
   logic                  mem_valid_q, mem_valid_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
   logic [DATA_WIDTH-1:0] sel_data;

`ifdef PERIPH_BUS_TIMEOUT_EN
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] cnt_q, cnt_d;
   logic       error_q, error_d;
`endif

   // Scan from the top so the lowest asserted index wins.
   always_comb begin
      sel_data = '0;
      for (int k = NUM_PERIPH - 1; k >= 0; k--) begin
         if (periph_valid_i[k]) begin
            sel_data = periph_data_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      cpu_valid_d = 1'b0;
      cpu_data_d  = cpu_data_q;
      mem_valid_d = 1'b0;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
`ifdef PERIPH_BUS_TIMEOUT_EN
      cnt_d       = cnt_q;
      error_d     = error_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cpu_valid_i && (cpu_read_i || cpu_write_i)) begin
               state_d     = S_ISSUE;
               busy_d      = 1'b1;
               mem_valid_d = 1'b1;
               mem_read_d  = cpu_read_i;
               mem_write_d = cpu_write_i;
               mem_addr_d  = cpu_addr_i;
               mem_data_d  = cpu_data_i;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
`ifdef PERIPH_BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_WAIT: begin
            // A response arriving on the expiry cycle still wins.
            if (|periph_valid_i) begin
               state_d     = S_RESP;
               cpu_valid_d = 1'b1;
               cpu_data_d  = mem_write_q ? '0 : sel_data;
`ifdef PERIPH_BUS_TIMEOUT_EN
               error_d     = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = S_RESP;
               cpu_valid_d = 1'b1;
               cpu_data_d  = '0;
               error_d     = 1'b1;
            end else begin
               cnt_d       = cnt_q + 8'd1;
`endif
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge mem_clk) begin
      if (cpu_reset) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         cpu_valid_q <= 1'b0;
         cpu_data_q  <= '0;
         mem_valid_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
`ifdef PERIPH_BUS_TIMEOUT_EN
         cnt_q       <= '0;
         error_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         cpu_valid_q <= cpu_valid_d;
         cpu_data_q  <= cpu_data_d;
         mem_valid_q <= mem_valid_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
`ifdef PERIPH_BUS_TIMEOUT_EN
         cnt_q       <= cnt_d;
         error_q     <= error_d;
`endif
      end
   end

   assign cpu_busy_o  = busy_q;
   assign cpu_valid_o = cpu_valid_q;
   assign cpu_data_o  = cpu_data_q;
   assign mem_valid_o = mem_valid_q;
   assign mem_read_o  = mem_read_q;
   assign mem_write_o = mem_write_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_data_o  = mem_data_q;
`ifdef PERIPH_BUS_TIMEOUT_EN
   assign cpu_error_o = error_q;
`else
   assign cpu_error_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_bridge.sv
`default_nettype none
// =============================================================================
// Module   : tb_periph_bus_bridge
// Brief    : Directed self-checking bench for periph_bus_bridge (defaults).
//            Timeout scenario selected by PERIPH_BUS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module tb_periph_bus_bridge;

   logic         mem_clk;
   logic         cpu_reset;
   logic         cpu_valid_i, cpu_read_i, cpu_write_i;
   logic [31:0]  cpu_addr_i, cpu_data_i;
   logic         cpu_busy_o, cpu_valid_o, cpu_error_o;
   logic [31:0]  cpu_data_o;
   logic         mem_valid_o, mem_read_o, mem_write_o;
   logic [31:0]  mem_addr_o, mem_data_o;
   logic [3:0]   periph_valid_i;
   logic [127:0] periph_data_i;

   int n_cmp = 0;
   int n_err = 0;

   periph_bus_bridge #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_PERIPH(4), .TIMEOUT_CYCLES(16)
   ) dut (
      .mem_clk(mem_clk), .cpu_reset(cpu_reset),
      .cpu_valid_i(cpu_valid_i), .cpu_read_i(cpu_read_i), .cpu_write_i(cpu_write_i),
      .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
      .cpu_busy_o(cpu_busy_o), .cpu_valid_o(cpu_valid_o),
      .cpu_data_o(cpu_data_o), .cpu_error_o(cpu_error_o),
      .mem_valid_o(mem_valid_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .periph_valid_i(periph_valid_i), .periph_data_i(periph_data_i)
   );

   initial mem_clk = 1'b0;
   always #5 mem_clk = ~mem_clk;

   task automatic tick();
      @(posedge mem_clk);
      #1;
   endtask

   task automatic send_req(input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d);
      cpu_valid_i = 1'b1;
      cpu_read_i  = rd;
      cpu_write_i = wr;
      cpu_addr_i  = a;
      cpu_data_i  = d;
      tick();
      cpu_valid_i = 1'b0;
      cpu_read_i  = 1'b0;
      cpu_write_i = 1'b0;
   endtask

   task automatic set_slot(input int k, input logic [31:0] v);
      periph_data_i[k*32 +: 32] = v;
   endtask

   task automatic test_reset();
      cpu_reset   = 1'b1;
      cpu_valid_i = 1'b1;
      cpu_read_i  = 1'b1;
      cpu_addr_i  = 32'hDEAD_0000;
      tick();
      tick();
      n_cmp++; if (cpu_busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", cpu_busy_o); end
      n_cmp++; if (cpu_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_cpu_valid: got %b expected 0", cpu_valid_o); end
      n_cmp++; if (cpu_error_o !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b expected 0", cpu_error_o); end
      n_cmp++; if (mem_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_valid: got %b expected 0", mem_valid_o); end
      n_cmp++; if ({mem_read_o, mem_write_o} !== 2'b00) begin n_err++; $display("FAIL reset_rw: got %b expected 00", {mem_read_o, mem_write_o}); end
      n_cmp++; if (cpu_data_o !== 32'h0) begin n_err++; $display("FAIL reset_cpu_data: got %h expected 0", cpu_data_o); end
      n_cmp++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr_o); end
      n_cmp++; if (mem_data_o !== 32'h0) begin n_err++; $display("FAIL reset_mem_data: got %h expected 0", mem_data_o); end
      cpu_reset   = 1'b0;
      cpu_valid_i = 1'b0;
      cpu_read_i  = 1'b0;
      tick();
   endtask

   task automatic test_read();
      send_req(1'b1, 1'b0, 32'h8000_0088, 32'h0);
      n_cmp++; if (mem_valid_o !== 1'b1) begin n_err++; $display("FAIL rd_mem_valid_n1: got %b expected 1", mem_valid_o); end
      n_cmp++; if ({mem_read_o, mem_write_o} !== 2'b10) begin n_err++; $display("FAIL rd_rw: got %b expected 10", {mem_read_o, mem_write_o}); end
      n_cmp++; if (mem_addr_o !== 32'h8000_0088) begin n_err++; $display("FAIL rd_addr: got %h expected 80000088", mem_addr_o); end
      n_cmp++; if (cpu_busy_o !== 1'b1) begin n_err++; $display("FAIL rd_busy_issue: got %b expected 1", cpu_busy_o); end
      tick();
      n_cmp++; if (mem_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_mem_valid_n2: got %b expected 0", mem_valid_o); end
      n_cmp++; if (cpu_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_cpu_valid_n2: got %b expected 0", cpu_valid_o); end
      periph_valid_i = 4'b0010;
      set_slot(0, 32'hDEAD_BEEF);
      set_slot(1, 32'h0000_00A5);
      tick();
      periph_valid_i = 4'b0000;
      n_cmp++; if (cpu_valid_o !== 1'b1) begin n_err++; $display("FAIL rd_cpu_valid_n3: got %b expected 1", cpu_valid_o); end
      n_cmp++; if (cpu_data_o !== 32'h0000_00A5) begin n_err++; $display("FAIL rd_data: got %h expected 000000a5", cpu_data_o); end
      n_cmp++; if (cpu_error_o !== 1'b0) begin n_err++; $display("FAIL rd_error: got %b expected 0", cpu_error_o); end
      n_cmp++; if (mem_read_o !== 1'b1) begin n_err++; $display("FAIL rd_hold_resp: got %b expected 1", mem_read_o); end
      tick();
      n_cmp++; if ({cpu_valid_o, cpu_busy_o} !== 2'b00) begin n_err++; $display("FAIL rd_idle: got %b expected 00", {cpu_valid_o, cpu_busy_o}); end
      n_cmp++; if (cpu_data_o !== 32'h0000_00A5) begin n_err++; $display("FAIL rd_data_hold: got %h expected 000000a5", cpu_data_o); end
   endtask

   task automatic test_write();
      send_req(1'b0, 1'b1, 32'h8000_0084, 32'h0000_00FF);
      n_cmp++; if ({mem_valid_o, mem_read_o, mem_write_o} !== 3'b101) begin n_err++; $display("FAIL wr_issue: got %b expected 101", {mem_valid_o, mem_read_o, mem_write_o}); end
      n_cmp++; if (mem_data_o !== 32'h0000_00FF) begin n_err++; $display("FAIL wr_mem_data: got %h expected 000000ff", mem_data_o); end
      tick();
      n_cmp++; if (mem_valid_o !== 1'b0) begin n_err++; $display("FAIL wr_single_cycle: got %b expected 0", mem_valid_o); end
      periph_valid_i = 4'b1000;
      set_slot(3, 32'h1234_5678);
      tick();
      periph_valid_i = 4'b0000;
      n_cmp++; if (cpu_valid_o !== 1'b1) begin n_err++; $display("FAIL wr_cpu_valid: got %b expected 1", cpu_valid_o); end
      n_cmp++; if (cpu_data_o !== 32'h0) begin n_err++; $display("FAIL wr_cpu_data: got %h expected 0", cpu_data_o); end
      tick();
   endtask

   task automatic test_priority();
      send_req(1'b1, 1'b0, 32'h8000_0010, 32'h0);
      tick();
      periph_valid_i = 4'b0101;
      set_slot(0, 32'h11);
      set_slot(2, 32'h22);
      tick();
      periph_valid_i = 4'b0000;
      n_cmp++; if (cpu_data_o !== 32'h11) begin n_err++; $display("FAIL prio_0_2: got %h expected 00000011", cpu_data_o); end
      tick();
      send_req(1'b1, 1'b0, 32'h8000_0014, 32'h0);
      tick();
      periph_valid_i = 4'b1010;
      set_slot(1, 32'h33);
      set_slot(3, 32'h44);
      tick();
      periph_valid_i = 4'b0000;
      n_cmp++; if (cpu_data_o !== 32'h33) begin n_err++; $display("FAIL prio_1_3: got %h expected 00000033", cpu_data_o); end
      tick();
   endtask

   task automatic test_ignored();
      cpu_valid_i = 1'b1;
      cpu_read_i  = 1'b0;
      cpu_write_i = 1'b0;
      tick();
      cpu_valid_i = 1'b0;
      n_cmp++; if ({cpu_busy_o, mem_valid_o} !== 2'b00) begin n_err++; $display("FAIL no_rw_ignored: got %b expected 00", {cpu_busy_o, mem_valid_o}); end
      // Response in ISSUE must not complete the transaction.
      send_req(1'b1, 1'b0, 32'h8000_0020, 32'h0);
      periph_valid_i = 4'b0001;
      set_slot(0, 32'h55);
      tick();
      periph_valid_i = 4'b0000;
      tick();
      n_cmp++; if ({cpu_valid_o, cpu_busy_o} !== 2'b01) begin n_err++; $display("FAIL issue_resp_ignored: got %b expected 01", {cpu_valid_o, cpu_busy_o}); end
      periph_valid_i = 4'b0100;
      set_slot(2, 32'h66);
      tick();
      periph_valid_i = 4'b0000;
      n_cmp++; if (cpu_data_o !== 32'h66) begin n_err++; $display("FAIL wait_resp_data: got %h expected 00000066", cpu_data_o); end
      tick();
   endtask

`ifdef PERIPH_BUS_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      send_req(1'b1, 1'b0, 32'h8000_00F0, 32'h0);
      n = 0;
      while (cpu_valid_o !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      n_cmp++; if (n !== 17) begin n_err++; $display("FAIL to_latency: got %0d cycles expected 17", n); end
      n_cmp++; if (cpu_error_o !== 1'b1) begin n_err++; $display("FAIL to_error: got %b expected 1", cpu_error_o); end
      n_cmp++; if (cpu_data_o !== 32'h0) begin n_err++; $display("FAIL to_data: got %h expected 0", cpu_data_o); end
      periph_valid_i = 4'b0001;
      set_slot(0, 32'h77);
      tick();
      periph_valid_i = 4'b0000;
      n_cmp++; if ({cpu_valid_o, cpu_busy_o, cpu_error_o} !== 3'b001) begin n_err++; $display("FAIL to_late_ignored: got %b expected 001", {cpu_valid_o, cpu_busy_o, cpu_error_o}); end
      n_cmp++; if (cpu_data_o !== 32'h0) begin n_err++; $display("FAIL to_late_data: got %h expected 0", cpu_data_o); end
      send_req(1'b1, 1'b0, 32'h8000_00F4, 32'h0);
      tick();
      periph_valid_i = 4'b0001;
      set_slot(0, 32'h99);
      tick();
      periph_valid_i = 4'b0000;
      n_cmp++; if ({cpu_valid_o, cpu_error_o} !== 2'b10) begin n_err++; $display("FAIL to_error_clear: got %b expected 10", {cpu_valid_o, cpu_error_o}); end
      tick();
   endtask
`else
   task automatic test_no_timeout();
      logic seen;
      send_req(1'b1, 1'b0, 32'h8000_00F0, 32'h0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (cpu_valid_o !== 1'b0) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL nt_no_resp: got %b expected 0", seen); end
      n_cmp++; if ({cpu_busy_o, cpu_error_o} !== 2'b10) begin n_err++; $display("FAIL nt_wait_hold: got %b expected 10", {cpu_busy_o, cpu_error_o}); end
      periph_valid_i = 4'b0001;
      set_slot(0, 32'h99);
      tick();
      periph_valid_i = 4'b0000;
      n_cmp++; if ({cpu_valid_o, cpu_error_o} !== 2'b10) begin n_err++; $display("FAIL nt_resp: got %b expected 10", {cpu_valid_o, cpu_error_o}); end
      n_cmp++; if (cpu_data_o !== 32'h99) begin n_err++; $display("FAIL nt_data: got %h expected 00000099", cpu_data_o); end
      tick();
   endtask
`endif

   task automatic test_busy_reset();
      send_req(1'b1, 1'b0, 32'h8000_0100, 32'h0);
      tick();
      send_req(1'b0, 1'b1, 32'h8000_0200, 32'h0000_00AB);
      n_cmp++; if (mem_valid_o !== 1'b0) begin n_err++; $display("FAIL busy_req_dropped: got %b expected 0", mem_valid_o); end
      n_cmp++; if (mem_addr_o !== 32'h8000_0100) begin n_err++; $display("FAIL busy_addr_kept: got %h expected 80000100", mem_addr_o); end
      cpu_reset = 1'b1;
      tick();
      cpu_reset = 1'b0;
      n_cmp++; if ({cpu_busy_o, cpu_valid_o, cpu_error_o, mem_valid_o, mem_read_o, mem_write_o} !== 6'b0) begin n_err++; $display("FAIL midreset_flags: got %b expected 000000", {cpu_busy_o, cpu_valid_o, cpu_error_o, mem_valid_o, mem_read_o, mem_write_o}); end
      n_cmp++; if ({cpu_data_o, mem_addr_o, mem_data_o} !== 96'h0) begin n_err++; $display("FAIL midreset_data: got %h expected 0", {cpu_data_o, mem_addr_o, mem_data_o}); end
      send_req(1'b0, 1'b1, 32'h8000_0300, 32'h0000_005A);
      n_cmp++; if ({mem_valid_o, mem_write_o} !== 2'b11) begin n_err++; $display("FAIL post_reset_issue: got %b expected 11", {mem_valid_o, mem_write_o}); end
      n_cmp++; if (mem_addr_o !== 32'h8000_0300) begin n_err++; $display("FAIL post_reset_addr: got %h expected 80000300", mem_addr_o); end
      tick();
      periph_valid_i = 4'b0010;
      tick();
      periph_valid_i = 4'b0000;
      n_cmp++; if ({cpu_valid_o, cpu_data_o} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL post_reset_resp: got %b/%h expected 1/0", cpu_valid_o, cpu_data_o); end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cpu_reset      = 1'b1;
      cpu_valid_i    = 1'b0;
      cpu_read_i     = 1'b0;
      cpu_write_i    = 1'b0;
      cpu_addr_i     = '0;
      cpu_data_i     = '0;
      periph_valid_i = '0;
      periph_data_i  = '0;
      test_reset();
      test_read();
      test_write();
      test_priority();
      test_ignored();
`ifdef PERIPH_BUS_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_busy_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/periph_bus_bridge.md
PERIPH_BUS_BRIDGE -- requirements
Module: periph_bus_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bus data width.
REQ-003 SHALL have parameter NUM_PERIPH, default 4, number of attached peripheral response ports.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, WAIT cycles before abort (range 1..255).
REQ-005 SHALL have ports mem_clk in 1 clock; cpu_reset in 1, the reset. One clock; reset is synchronous and active-high.
REQ-006 SHALL have CPU request ports cpu_valid_i in 1; cpu_read_i in 1; cpu_write_i in 1; cpu_addr_i in ADDR_WIDTH; cpu_data_i in DATA_WIDTH.
REQ-007 SHALL have CPU response ports cpu_busy_o out 1, transaction in flight; cpu_valid_o out 1, response strobe; cpu_data_o out DATA_WIDTH, read data; cpu_error_o out 1, abort flag.
REQ-008 SHALL have peripheral request ports mem_valid_o out 1; mem_read_o out 1; mem_write_o out 1; mem_addr_o out ADDR_WIDTH; mem_data_o out DATA_WIDTH, broadcast to all peripherals.
REQ-009 SHALL have peripheral response ports periph_valid_i in NUM_PERIPH, one strobe per peripheral; periph_data_i in NUM_PERIPH*DATA_WIDTH, peripheral k at bits [k*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-011 IDLE: cpu_valid_i=1 with cpu_read_i or cpu_write_i =1 SHALL latch read, write, addr, data and go ISSUE; cpu_valid_i with both read and write 0 SHALL be ignored.
REQ-012 ISSUE: mem_valid_o SHALL be 1 for exactly one cycle with latched read/write/addr/data; next state WAIT, timeout counter cleared.
REQ-013 mem_read_o, mem_write_o, mem_addr_o, mem_data_o SHALL hold latched values from ISSUE through RESP; mem_valid_o SHALL be 0 outside ISSUE.
REQ-014 WAIT: any periph_valid_i bit set SHALL capture the data of the lowest-index asserted peripheral, clear error, go RESP.
REQ-015 WAIT with no response SHALL increment counter; handling of counter expiry per REQ-024/025.
REQ-016 RESP: cpu_valid_o=1 for exactly one cycle with cpu_data_o, cpu_error_o valid; next state IDLE.
REQ-017 For write transactions cpu_data_o SHALL be 0 in RESP; peripheral-returned data ignored.
REQ-018 cpu_busy_o SHALL be 1 in ISSUE, WAIT, RESP; 0 in IDLE; cpu_valid_i while busy SHALL be ignored (not queued).
REQ-019 Latency: request sampled at edge N; mem_valid_o high cycle N+1; peripheral responding one cycle later gives cpu_valid_o high cycle N+3.
REQ-020 periph_valid_i outside WAIT SHALL be ignored, including late responses after timeout.
REQ-021 cpu_data_o and cpu_error_o SHALL hold last response value until next RESP.

Reset
REQ-022 cpu_reset=1 at any edge, including mid-transaction, SHALL force IDLE, discard pending request, clear counter.
REQ-023 Reset values: cpu_busy_o, cpu_valid_o, cpu_error_o, mem_valid_o, mem_read_o, mem_write_o = 0; cpu_data_o, mem_addr_o, mem_data_o = 0.

Configuration
REQ-024 With macro PERIPH_BUS_TIMEOUT_EN defined: after TIMEOUT_CYCLES consecutive WAIT cycles without response, SHALL go RESP with cpu_error_o=1, cpu_data_o=0; simultaneous response and expiry SHALL take the response.
REQ-025 Without PERIPH_BUS_TIMEOUT_EN: no counter logic, WAIT SHALL persist until a response or reset, cpu_error_o SHALL be constant 0.

Verification
REQ-026 Read addr 0x80000088, peripheral 1 asserts valid with data 0x000000A5 one cycle after mem_valid_o -> cpu_valid_o at N+3, cpu_data_o=0x000000A5, cpu_error_o=0.
REQ-027 Write addr 0x80000084 data 0xFF -> single-cycle mem_valid_o, mem_write_o=1, mem_data_o=0xFF; on response cpu_valid_o=1, cpu_data_o=0.
REQ-028 Peripherals 0 and 2 respond same cycle, data 0x11 and 0x22 -> cpu_data_o=0x11.
REQ-029 TIMEOUT_EN, TIMEOUT_CYCLES=16, no responder -> cpu_valid_o=1, cpu_error_o=1, cpu_data_o=0 after 16 WAIT cycles; late periph_valid_i next cycle ignored.
REQ-030 Second cpu_valid_i during WAIT, then cpu_reset in WAIT -> second request dropped, all outputs 0 next cycle, new request accepted afterward.
